// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: word-addressed RAM behind independent single-outstanding
// write and read engines. Supports FIXED/INCR bursts; bad size/burst or range -> SLVERR.
module axi_mem_responder #(
  parameter int ID_WIDTH   = 10,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    s_awready,
  input  logic                    s_awvalid,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  output logic                    s_wready,
  input  logic                    s_wvalid,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_bready,
  output logic                    s_bvalid,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_arready,
  input  logic                    s_arvalid,
  input  logic [ID_WIDTH-1:0]     s_arid,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic                    s_rready,
  output logic                    s_rvalid,
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SIZE   = $clog2(STRB_W);
  // One spare MSB so an INCR burst near the top of the address space never wraps into range.
  localparam int IDX_W  = ADDR_WIDTH - SIZE + 1;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);
  localparam logic [2:0]       SIZE_L  = 3'(SIZE);
  localparam logic [1:0]       OKAY    = 2'b00;
  localparam logic [1:0]       SLVERR  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // ---------------- write engine ----------------
  wstate_t               r_wstate, w_wnext;
  logic                  r_awready, r_wready, r_bvalid;
  logic [ID_WIDTH-1:0]   r_wid, r_bid;
  logic [1:0]            r_bresp;
  logic [IDX_W-1:0]      r_widx;
  logic [7:0]            r_wlen, r_wcnt;
  logic                  r_wfixed, r_wcfg_err, r_werr;
  logic                  w_aw_hs, w_w_hs, w_b_hs, w_aw_cfg_err;
  logic                  w_w_inr, w_w_final, w_w_beat_err, w_mem_we;

  assign w_aw_hs      = s_awvalid & r_awready;
  assign w_w_hs       = s_wvalid & r_wready;
  assign w_b_hs       = s_bready & r_bvalid;
  assign w_aw_cfg_err = (s_awsize != SIZE_L) | s_awburst[1];
  assign w_w_inr      = r_widx < DEPTH_I;
  assign w_w_final    = r_wcnt == r_wlen;
  assign w_w_beat_err = ~w_w_inr | (s_wlast != w_w_final);
  assign w_mem_we     = w_w_hs & w_w_inr & ~r_wcfg_err & ~rst;

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wnext = W_DATA;
      W_DATA:  if (w_w_hs && w_w_final) w_wnext = W_RESP;
      W_RESP:  if (w_b_hs) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate   <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bid      <= '0;
      r_bresp    <= OKAY;
      r_wid      <= '0;
      r_widx     <= '0;
      r_wlen     <= '0;
      r_wcnt     <= '0;
      r_wfixed   <= 1'b0;
      r_wcfg_err <= 1'b0;
      r_werr     <= 1'b0;
    end else begin
      r_wstate  <= w_wnext;
      r_awready <= (w_wnext == W_IDLE);
      r_wready  <= (w_wnext == W_DATA);
      r_bvalid  <= (w_wnext == W_RESP);
      if (w_aw_hs) begin
        r_wid      <= s_awid;
        r_widx     <= {1'b0, s_awaddr[ADDR_WIDTH-1:SIZE]};
        r_wlen     <= s_awlen;
        r_wcnt     <= '0;
        r_wfixed   <= (s_awburst == 2'b00);
        r_wcfg_err <= w_aw_cfg_err;
        r_werr     <= w_aw_cfg_err;
      end
      if (w_w_hs) begin
        r_werr <= r_werr | w_w_beat_err;
        r_wcnt <= r_wcnt + 8'd1;
        if (!r_wfixed) r_widx <= r_widx + IDX_W'(1);
        if (w_w_final) begin
          r_bid   <= r_wid;
          r_bresp <= (r_werr | w_w_beat_err) ? SLVERR : OKAY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < STRB_W; b++)
        if (s_wstrb[b]) r_mem[r_widx[RAM_AW-1:0]][b*8 +: 8] <= s_wdata[b*8 +: 8];
    end
  end

  assign s_awready = r_awready;
  assign s_wready  = r_wready;
  assign s_bvalid  = r_bvalid;
  assign s_bid     = r_bid;
  assign s_bresp   = r_bresp;

  // ---------------- read engine ----------------
  rstate_t               r_rstate, w_rnext;
  logic                  r_arready, r_rvalid, r_rlast;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic [IDX_W-1:0]      r_ridx;
  logic [7:0]            r_rlen, r_rcnt;
  logic                  r_rfixed, r_rcfg_err;
  logic                  w_ar_hs, w_r_hs, w_ar_cfg_err, w_beat_load;
  logic                  w_beat_ok, w_beat_last;
  logic [IDX_W-1:0]      w_beat_idx;

  assign w_ar_hs      = s_arvalid & r_arready;
  assign w_r_hs       = s_rready & r_rvalid;
  assign w_ar_cfg_err = (s_arsize != SIZE_L) | s_arburst[1];
  assign w_beat_load  = w_ar_hs | (w_r_hs & ~r_rlast);
  // Beat 0 comes from the AR channel; later beats advance from the current one.
  assign w_beat_idx   = w_ar_hs ? {1'b0, s_araddr[ADDR_WIDTH-1:SIZE]}
                      : (r_rfixed ? r_ridx : r_ridx + IDX_W'(1));
  assign w_beat_ok    = (w_beat_idx < DEPTH_I) & ~(w_ar_hs ? w_ar_cfg_err : r_rcfg_err);
  assign w_beat_last  = w_ar_hs ? (s_arlen == 8'd0) : ((r_rcnt + 8'd1) == r_rlen);

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate   <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rid      <= '0;
      r_rdata    <= '0;
      r_rresp    <= OKAY;
      r_rlast    <= 1'b0;
      r_ridx     <= '0;
      r_rlen     <= '0;
      r_rcnt     <= '0;
      r_rfixed   <= 1'b0;
      r_rcfg_err <= 1'b0;
    end else begin
      r_rstate  <= w_rnext;
      r_arready <= (w_rnext == R_IDLE);
      r_rvalid  <= (w_rnext == R_DATA);
      if (w_beat_load) begin
        r_ridx  <= w_beat_idx;
        r_rdata <= w_beat_ok ? r_mem[w_beat_idx[RAM_AW-1:0]] : '0;
        r_rresp <= w_beat_ok ? OKAY : SLVERR;
        r_rlast <= w_beat_last;
      end
      if (w_ar_hs) begin
        r_rid      <= s_arid;
        r_rlen     <= s_arlen;
        r_rcnt     <= '0;
        r_rfixed   <= (s_arburst == 2'b00);
        r_rcfg_err <= w_ar_cfg_err;
      end else if (w_beat_load) begin
        r_rcnt <= r_rcnt + 8'd1;
      end
    end
  end

  assign s_arready = r_arready;
  assign s_rvalid  = r_rvalid;
  assign s_rid     = r_rid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = r_rresp;
  assign s_rlast   = r_rlast;
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: table of single-beat transactions plus
// hand-written burst, error, backpressure and reset sequences.
module tb_axi_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_awready, s_awvalid;
  logic [9:0]  s_awid;
  logic [19:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_wready, s_wvalid, s_wlast;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_bready, s_bvalid;
  logic [9:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_arready, s_arvalid;
  logic [9:0]  s_arid;
  logic [19:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_rready, s_rvalid, s_rlast;
  logic [9:0]  s_rid;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;

  axi_mem_responder dut (
    .clk(clk), .rst(rst),
    .s_awready(s_awready), .s_awvalid(s_awvalid), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wready(s_wready), .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bready(s_bready), .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_arready(s_arready), .s_arvalid(s_arvalid), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rready(s_rready), .s_rvalid(s_rvalid), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          wr;
    logic [9:0]  id;
    logic [19:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t        vt [14];
  logic [63:0] bd [4];
  logic [7:0]  bs [4];
  logic [63:0] ed [4];
  logic [1:0]  er [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_aw(input logic [9:0] id, input logic [19:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    @(negedge clk);
    s_awvalid = 1'b1; s_awid = id; s_awaddr = a; s_awlen = len; s_awsize = sz; s_awburst = bu;
    while (!s_awready && n < 50) begin @(negedge clk); n++; end
    chk("awready_wait", 64'(n < 50), 64'd1);
    @(posedge clk); #1 s_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] st, input logic last);
    int n = 0;
    @(negedge clk);
    s_wvalid = 1'b1; s_wdata = d; s_wstrb = st; s_wlast = last;
    while (!s_wready && n < 50) begin @(negedge clk); n++; end
    chk("wready_wait", 64'(n < 50), 64'd1);
    @(posedge clk); #1 s_wvalid = 1'b0;
  endtask

  task automatic wait_b(input logic [9:0] eid, input logic [1:0] eresp, input int hold);
    int n = 0;
    @(negedge clk);
    while (!s_bvalid && n < 50) begin @(negedge clk); n++; end
    chk("bvalid_wait", 64'(n < 50), 64'd1);
    chk("bid", s_bid, eid);
    chk("bresp", s_bresp, eresp);
    chk("awready_in_resp", s_awready, 0);
    repeat (hold) begin
      @(negedge clk);
      chk("bvalid_hold", s_bvalid, 1);
      chk("bid_hold", s_bid, eid);
      chk("bresp_hold", s_bresp, eresp);
      chk("awready_hold", s_awready, 0);
    end
    s_bready = 1'b1;
    @(posedge clk); #1 s_bready = 1'b0;
    chk("awready_after_b", s_awready, 1);
  endtask

  task automatic send_ar(input logic [9:0] id, input logic [19:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    @(negedge clk);
    s_arvalid = 1'b1; s_arid = id; s_araddr = a; s_arlen = len; s_arsize = sz; s_arburst = bu;
    while (!s_arready && n < 50) begin @(negedge clk); n++; end
    chk("arready_wait", 64'(n < 50), 64'd1);
    @(posedge clk); #1 s_arvalid = 1'b0;
    chk("rvalid_latency", s_rvalid, 1);
  endtask

  // Every beat must be presented with no gap; stall holds rready low first.
  task automatic get_r(input logic [63:0] d, input logic [1:0] rs, input logic last,
                       input logic [9:0] id, input int stall);
    int n = 0;
    @(negedge clk);
    while (!s_rvalid && n < 50) begin @(negedge clk); n++; end
    chk("rvalid_nogap", 64'(n), 64'd0);
    repeat (stall) begin
      @(negedge clk);
      chk("rdata_stall", s_rdata, d);
      chk("rvalid_stall", s_rvalid, 1);
    end
    chk("rdata", s_rdata, d);
    chk("rresp", s_rresp, rs);
    chk("rlast", s_rlast, last);
    chk("rid", s_rid, id);
    s_rready = 1'b1;
    @(posedge clk); #1 s_rready = 1'b0;
  endtask

  task automatic wr_burst(input logic [9:0] id, input logic [19:0] a, input logic [7:0] len,
                          input logic [1:0] bu, input logic [1:0] eresp);
    send_aw(id, a, len, 3'd3, bu);
    for (int i = 0; i <= int'(len); i++) send_w(bd[i], bs[i], i == int'(len));
    chk("b_latency", s_bvalid, 1);
    wait_b(id, eresp, 0);
  endtask

  task automatic rd_burst(input logic [9:0] id, input logic [19:0] a, input logic [7:0] len,
                          input logic [1:0] bu, input int stall);
    send_ar(id, a, len, 3'd3, bu);
    for (int i = 0; i <= int'(len); i++) get_r(ed[i], er[i], i == int'(len), id, stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 10'h3A5, 20'h00010, 3'd3, 2'b01, 64'h1122334455667788, 8'hFF, 64'h0, 2'b00};
    vt[1]  = '{1'b0, 10'h011, 20'h00010, 3'd3, 2'b01, 64'h0, 8'h0, 64'h1122334455667788, 2'b00};
    vt[2]  = '{1'b1, 10'h2AA, 20'h00018, 3'd3, 2'b01, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 2'b00};
    vt[3]  = '{1'b1, 10'h001, 20'h00018, 3'd3, 2'b01, 64'hDEADBEEFCAFEF00D, 8'hF0, 64'h0, 2'b00};
    vt[4]  = '{1'b0, 10'h3FF, 20'h00018, 3'd3, 2'b01, 64'h0, 8'h0, 64'hDEADBEEF89ABCDEF, 2'b00};
    vt[5]  = '{1'b1, 10'h055, 20'h01007, 3'd3, 2'b01, 64'hABCD, 8'hFF, 64'h0, 2'b10};
    vt[6]  = '{1'b0, 10'h056, 20'h01000, 3'd3, 2'b01, 64'h0, 8'h0, 64'h0, 2'b10};
    vt[7]  = '{1'b1, 10'h030, 20'h00030, 3'd3, 2'b01, 64'h5555555555555555, 8'hFF, 64'h0, 2'b00};
    vt[8]  = '{1'b1, 10'h031, 20'h00030, 3'd2, 2'b01, 64'h0, 8'hFF, 64'h0, 2'b10};
    vt[9]  = '{1'b0, 10'h032, 20'h00030, 3'd3, 2'b01, 64'h0, 8'h0, 64'h5555555555555555, 2'b00};
    vt[10] = '{1'b0, 10'h033, 20'h00013, 3'd3, 2'b01, 64'h0, 8'h0, 64'h1122334455667788, 2'b00};
    vt[11] = '{1'b0, 10'h034, 20'h00030, 3'd2, 2'b01, 64'h0, 8'h0, 64'h0, 2'b10};
    vt[12] = '{1'b1, 10'h035, 20'h00030, 3'd3, 2'b11, 64'h0, 8'hFF, 64'h0, 2'b10};
    vt[13] = '{1'b0, 10'h036, 20'h00030, 3'd3, 2'b01, 64'h0, 8'h0, 64'h5555555555555555, 2'b00};

    rst = 1'b1;
    s_awvalid = 0; s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 0;
    s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0;
    s_rready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", s_awready, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rdata", s_rdata, 0);
    @(negedge clk) rst = 1'b0;

    for (int v = 0; v < 14; v++) begin
      if (vt[v].wr) begin
        send_aw(vt[v].id, vt[v].addr, 8'd0, vt[v].size, vt[v].burst);
        send_w(vt[v].data, vt[v].strb, 1'b1);
        chk("b_latency", s_bvalid, 1);
        wait_b(vt[v].id, vt[v].exp_resp, 0);
      end else begin
        send_ar(vt[v].id, vt[v].addr, 8'd0, vt[v].size, vt[v].burst);
        get_r(vt[v].exp_data, vt[v].exp_resp, 1'b1, vt[v].id, 0);
      end
    end

    // INCR with partial strobe on beat 2 over a pre-filled region
    for (int i = 0; i < 4; i++) begin bd[i] = '1; bs[i] = 8'hFF; end
    wr_burst(10'h100, 20'h00100, 8'd3, 2'b01, 2'b00);
    for (int i = 0; i < 4; i++) bd[i] = 64'(i);
    bs[2] = 8'h0F;
    wr_burst(10'h101, 20'h00100, 8'd3, 2'b01, 2'b00);
    ed[0] = 64'h0; ed[1] = 64'h1; ed[2] = 64'hFFFFFFFF_00000002; ed[3] = 64'h3;
    for (int i = 0; i < 4; i++) er[i] = 2'b00;
    rd_burst(10'h102, 20'h00100, 8'd3, 2'b01, 0);

    // FIXED burst lands every beat on word 4
    for (int i = 0; i < 4; i++) begin bd[i] = 64'h40 + 64'(i); bs[i] = 8'hFF; end
    wr_burst(10'h110, 20'h00020, 8'd3, 2'b01, 2'b00);
    bd[0] = 64'hA; bd[1] = 64'hB; bd[2] = 64'hC; bd[3] = 64'hD;
    wr_burst(10'h111, 20'h00020, 8'd3, 2'b00, 2'b00);
    ed[0] = 64'hD; ed[1] = 64'h41; ed[2] = 64'h42; ed[3] = 64'h43;
    rd_burst(10'h112, 20'h00020, 8'd3, 2'b01, 0);

    // Burst crossing the end of memory, read back with rready toggling
    for (int i = 0; i < 4; i++) bd[i] = 64'h510 + 64'(i);
    wr_burst(10'h120, 20'h00FF0, 8'd3, 2'b01, 2'b10);
    ed[0] = 64'h510; ed[1] = 64'h511; ed[2] = 64'h0; ed[3] = 64'h0;
    er[0] = 2'b00; er[1] = 2'b00; er[2] = 2'b10; er[3] = 2'b10;
    rd_burst(10'h121, 20'h00FF0, 8'd3, 2'b01, 1);

    // B channel backpressure for 10 cycles
    send_aw(10'h123, 20'h00050, 8'd0, 3'd3, 2'b01);
    send_w(64'h5050, 8'hFF, 1'b1);
    wait_b(10'h123, 2'b00, 10);

    // WRAP is rejected and leaves RAM untouched
    for (int i = 0; i < 4; i++) bd[i] = 64'hEEEE;
    wr_burst(10'h130, 20'h00020, 8'd3, 2'b10, 2'b10);
    ed[0] = 64'hD; er[0] = 2'b00;
    rd_burst(10'h131, 20'h00020, 8'd0, 2'b01, 0);

    // wlast early, then wlast missing on the final beat
    send_aw(10'h140, 20'h00080, 8'd1, 3'd3, 2'b01);
    send_w(64'h1, 8'hFF, 1'b1);
    send_w(64'h2, 8'hFF, 1'b1);
    wait_b(10'h140, 2'b10, 0);
    send_aw(10'h141, 20'h00080, 8'd1, 3'd3, 2'b01);
    send_w(64'h1, 8'hFF, 1'b0);
    send_w(64'h2, 8'hFF, 1'b0);
    wait_b(10'h141, 2'b10, 0);

    // Reset after 2 of 4 beats
    send_aw(10'h0EE, 20'h00060, 8'd3, 3'd3, 2'b01);
    send_w(64'h600, 8'hFF, 1'b0);
    send_w(64'h601, 8'hFF, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_awready", s_awready, 0);
    chk("mid_rst_wready", s_wready, 0);
    chk("mid_rst_bvalid", s_bvalid, 0);
    chk("mid_rst_bid", s_bid, 0);
    chk("mid_rst_bresp", s_bresp, 0);
    chk("mid_rst_arready", s_arready, 0);
    chk("mid_rst_rvalid", s_rvalid, 0);
    chk("mid_rst_rid", s_rid, 0);
    chk("mid_rst_rdata", s_rdata, 0);
    chk("mid_rst_rresp", s_rresp, 0);
    chk("mid_rst_rlast", s_rlast, 0);
    @(negedge clk) rst = 1'b0;
    bd[0] = 64'h4040; bs[0] = 8'hFF;
    wr_burst(10'h150, 20'h00040, 8'd0, 2'b01, 2'b00);
    ed[0] = 64'h4040; er[0] = 2'b00;
    rd_burst(10'h151, 20'h00040, 8'd0, 2'b01, 0);
    ed[0] = 64'h600; ed[1] = 64'h601; er[1] = 2'b00;
    rd_burst(10'h152, 20'h00060, 8'd1, 2'b01, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 memory-mapped responder (slave endpoint) backed by an internal word-addressed RAM.
- Terminates the master side of an AXI pipeline register chain. Used as a scratch/test memory and as a protocol sink for register-slice and interconnect benches.
- Independent write and read engines, each with one outstanding transaction. Supports FIXED and INCR bursts.

Parameters:
- ID_WIDTH, 10, AWID/BID/ARID/RID width.
- ADDR_WIDTH, 20, byte address width.
- DATA_WIDTH, 64, WDATA/RDATA width; power of 2, >= 32.
- DEPTH, 512, RAM depth in DATA_WIDTH words.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_awready out 1, s_awvalid in 1, s_awid in ID_WIDTH, s_awaddr in ADDR_WIDTH, s_awlen in 8, s_awsize in 3, s_awburst in 2: write address channel
- s_wready out 1, s_wvalid in 1, s_wdata in DATA_WIDTH, s_wstrb in DATA_WIDTH/8, s_wlast in 1: write data channel
- s_bready in 1, s_bvalid out 1, s_bid out ID_WIDTH, s_bresp out 2: write response channel
- s_arready out 1, s_arvalid in 1, s_arid in ID_WIDTH, s_araddr in ADDR_WIDTH, s_arlen in 8, s_arsize in 3, s_arburst in 2: read address channel
- s_rready in 1, s_rvalid out 1, s_rid out ID_WIDTH, s_rdata out DATA_WIDTH, s_rresp out 2, s_rlast out 1: read data channel

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all ready/valid outputs 0; bid, bresp, rid, rdata, rresp, rlast 0. FSMs return to IDLE. RAM contents are not cleared.
- Word index = addr >> log2(DATA_WIDTH/8). Low address bits are ignored.
- Range check: a beat is in range iff the full-width word index < DEPTH. There is no wrap-around.
- Write FSM W_IDLE / W_DATA / W_RESP:
  - W_IDLE: awready=1, wready=0. On AW handshake, latch id, index, len, burst, and error flag, then go to W_DATA.
  - Error flag is set if awsize != log2(DATA_WIDTH/8) or awburst is WRAP (2'b10) or reserved (2'b11).
  - W_DATA: wready=1. Each W handshake writes the bytes selected by wstrb to RAM[index], only if the beat is in range and no burst error.
  - INCR increments index per beat; FIXED holds it.
  - A beat counter counts 0..len. The burst ends on the beat where count==len, regardless of wlast.
  - wlast asserted early, or missing on the final beat, sets the sticky error flag.
  - Any out-of-range beat also sets the sticky error flag.
  - W_RESP: bvalid=1, bid=latched id, bresp=SLVERR(2'b10) if the sticky flag is set, else OKAY. Hold stable until bready, then go to W_IDLE.
  - Latency: last W handshake at cycle N gives bvalid at N+1; awready is reasserted the cycle after the B handshake.
- Read FSM R_IDLE / R_DATA:
  - R_IDLE: arready=1. On AR handshake, register beat 0 (rdata, rresp, rlast = (len==0), rid) and go to R_DATA.
  - R_DATA: rvalid=1. On R handshake with a non-last beat, load the next beat at the same edge (1 beat/cycle back-to-back). After the last beat, go to R_IDLE.
  - Latency: AR handshake at cycle N gives rvalid at N+1.
  - Per-beat rresp = SLVERR with rdata=0 if the beat is out of range or the burst is in error; otherwise OKAY with RAM data.
  - Erroneous bursts still return exactly len+1 beats.
- Outputs hold stable while valid is high and ready is low.
- Read and write engines run concurrently. A read beat captured at the same edge as a write to the same word returns the pre-write data.
- W beats arriving before AW stall (wready=0) until AW is accepted.
- rst asserted mid-burst abandons the transaction with no response. A partially written burst leaves the already-written beats in RAM.

Test Plan:
1. Single beats (DATA_WIDTH=64, DEPTH=512):
   - Write awaddr=0x10, len=0, wdata=0x1122334455667788, wstrb=0xFF → bvalid at cycle N+1, bresp=0, bid=awid.
   - Read araddr=0x10, len=0 → rdata=0x1122334455667788, rlast=1, rresp=0, rvalid one cycle after AR handshake.
2. INCR with partial strobe:
   - Fill words 0x20..0x23 with 0xFF..FF, then INCR len=3 at 0x100 with data 0,1,2,3 and wstrb=0x0F on beat 2.
   - Read back → beat 2 = 0xFFFFFFFF_00000002; other beats exact.
   - Back-to-back rvalid with rready=1, rlast only on beat 3.
3. FIXED burst: len=3 at 0x20, data A,B,C,D → word 4 = D, words 5-7 unchanged, bresp=OKAY.
4. Out of range:
   - INCR len=3 at 0xFF0 (word 510) → words 510/511 written, bresp=SLVERR.
   - Read same burst → rresp OKAY,OKAY,SLVERR,SLVERR, with rdata=0 on the last two beats.
5. Backpressure and errors:
   - bready held low 10 cycles → bvalid/bid/bresp stable, awready=0 throughout.
   - rready toggling 1/0 → no beat lost or duplicated.
   - awburst=WRAP → no RAM change, bresp=SLVERR.
6. Reset mid-burst: rst for 1 cycle after 2 of 4 W beats → next cycle all outputs at reset values; a subsequent single write/read to 0x40 completes with OKAY.
